// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : ccff_chain_loader
// Purpose  : Configuration-chain sequencer for the IO tile column. Flushes
//            the ccff_head -> ccff_tail scan chain and probes its length.
//            It then serialises a word-wide bitstream into the chain, MSB
//            first. IO_ISOL_N is held low until the load has completed and
//            been verified.
// Ports    : prog_clk      - single clock for controller and chain
//            pReset_n      - asynchronous active-low reset
//            start         - one-cycle pulse starting a load (ignored if busy)
//            cfg_data      - bitstream word, MSB shifted first
//            cfg_valid     - word valid (handshake with cfg_ready)
//            cfg_ready     - loader can take a word this cycle
//            ccff_head     - registered serial data into the chain
//            ccff_shift_en - registered shift enable for the chain clock gate
//            ccff_tail     - output of the last chain flip-flop
//            IO_ISOL_N     - IO isolation, 0 = isolated
//            busy/done/err - status flags
// Revision : 1.0 - initial release
// ============================================================================
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 128,
    parameter int WORD_W    = 8,
    parameter int ISOL_DLY  = 4
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              IO_ISOL_N,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int c_CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int c_NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int c_WCNT_W = $clog2(c_NWORDS + 1);
    localparam int c_BIT_W  = $clog2(WORD_W + 1);
    localparam int c_DLY_W  = $clog2(ISOL_DLY + 1);

    localparam logic [c_CNT_W-1:0]  c_LEN   = c_CNT_W'(CHAIN_LEN);
    localparam logic [c_CNT_W-1:0]  c_ONE   = c_CNT_W'(1);
    localparam logic [c_WCNT_W-1:0] c_WORDS = c_WCNT_W'(c_NWORDS);
    localparam logic [c_DLY_W-1:0]  c_DLY   = c_DLY_W'(ISOL_DLY);
    localparam logic [c_BIT_W-1:0]  c_WREST = c_BIT_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FLUSH  = 3'd1,
        S_PROBE  = 3'd2,
        S_LOAD   = 3'd3,
        S_SETTLE = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;      // shifts issued in the current phase
    logic [c_DLY_W-1:0]  r_dly;      // settle cycle index
    logic [c_WCNT_W-1:0] r_words;    // words accepted in this load
    logic [c_BIT_W-1:0]  r_bits;     // bits of the current word still to be placed on head
    logic [WORD_W-1:0]   r_sr;       // remaining bits, next one at the MSB
    logic                r_head;
    logic                r_shift_en;
    logic                r_isol_n;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    // The word buffer is empty once its last bit has been moved onto head,
    // so a new word can be taken in the very cycle that last bit shifts and
    // the next MSB follows without a bubble.
    assign cfg_ready = (r_state == S_LOAD) && (r_words != c_WORDS) && (r_bits == '0);

    assign ccff_head     = r_head;
    assign ccff_shift_en = r_shift_en;
    assign IO_ISOL_N     = r_isol_n;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_dly      <= '0;
            r_words    <= '0;
            r_bits     <= '0;
            r_sr       <= '0;
            r_head     <= 1'b0;
            r_shift_en <= 1'b0;
            r_isol_n   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        // First flush shift is issued straight away.
                        r_state    <= S_FLUSH;
                        r_cnt      <= c_ONE;
                        r_head     <= 1'b0;
                        r_shift_en <= 1'b1;
                        r_isol_n   <= 1'b0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_words    <= '0;
                        r_bits     <= '0;
                    end
                end

                S_FLUSH: begin
                    if (r_cnt == c_LEN) begin
                        r_state <= S_PROBE;
                        r_head  <= 1'b1;     // the single marker bit
                        r_cnt   <= c_ONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_PROBE: begin
                    if (r_shift_en) begin
                        // Tail now reflects probe shift r_cnt-1, which must be 0.
                        if ((r_cnt != c_ONE) && ccff_tail) begin
                            r_state    <= S_ERROR;
                            r_shift_en <= 1'b0;
                            r_err      <= 1'b1;
                            r_busy     <= 1'b0;
                        end else if (r_cnt == c_LEN) begin
                            r_shift_en <= 1'b0;
                        end else begin
                            r_head <= 1'b0;
                            r_cnt  <= r_cnt + 1'b1;
                        end
                    end else begin
                        // One cycle after the final probe shift: marker must be at the tail.
                        if (ccff_tail) begin
                            r_state <= S_LOAD;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= S_ERROR;
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end

                S_LOAD: begin
                    if (r_cnt == c_LEN) begin
                        // Leftover low-order bits of a partial final word are dropped.
                        r_state    <= S_SETTLE;
                        r_shift_en <= 1'b0;
                        r_dly      <= c_DLY_W'(1);
                    end else if (r_bits != '0) begin
                        r_head     <= r_sr[WORD_W-1];
                        r_sr       <= r_sr << 1;
                        r_bits     <= r_bits - 1'b1;
                        r_shift_en <= 1'b1;
                        r_cnt      <= r_cnt + 1'b1;
                    end else if (cfg_valid && cfg_ready) begin
                        r_head     <= cfg_data[WORD_W-1];
                        r_sr       <= cfg_data << 1;
                        r_bits     <= c_WREST;
                        r_words    <= r_words + 1'b1;
                        r_shift_en <= 1'b1;
                        r_cnt      <= r_cnt + 1'b1;
                    end else begin
                        // Stall: head keeps its value, chain clock gated off.
                        r_shift_en <= 1'b0;
                    end
                end

                S_SETTLE: begin
                    if (r_dly == c_DLY) begin
                        r_state  <= S_DONE;
                        r_isol_n <= 1'b1;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                    end else begin
                        r_dly <= r_dly + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccff_chain_loader
// Purpose  : Self-checking bench for ccff_chain_loader. Instance A
//            (16-flop chain, 8-bit words) uses a behavioural chain of
//            selectable length and a scoreboard of expected head bits.
//            Instance B (12-flop chain) covers the partial final word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ccff_chain_loader;

    localparam int L  = 16;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int L2 = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- instance A ----------------
    logic         a_start = 1'b0;
    logic [W-1:0] a_data = '0;
    logic         a_valid = 1'b0;
    logic         a_ready, a_head, a_en, a_tail, a_isol, a_busy, a_done, a_err;
    logic [31:0]  a_chain = '0;
    int           a_len = L;

    assign a_tail = a_chain[5'(a_len - 1)];
    always @(posedge clk) if (a_en) a_chain <= {a_chain[30:0], a_head};

    ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W), .ISOL_DLY(D)) u_dut_a (
        .prog_clk(clk), .pReset_n(rst_n), .start(a_start),
        .cfg_data(a_data), .cfg_valid(a_valid), .cfg_ready(a_ready),
        .ccff_head(a_head), .ccff_shift_en(a_en), .ccff_tail(a_tail),
        .IO_ISOL_N(a_isol), .busy(a_busy), .done(a_done), .err(a_err)
    );

    // ---------------- instance B ----------------
    logic         b_start = 1'b0;
    logic [W-1:0] b_data = '0;
    logic         b_valid = 1'b0;
    logic         b_ready, b_head, b_en, b_tail, b_isol, b_busy, b_done, b_err;
    logic [31:0]  b_chain = '0;

    assign b_tail = b_chain[L2-1];
    always @(posedge clk) if (b_en) b_chain <= {b_chain[30:0], b_head};

    ccff_chain_loader #(.CHAIN_LEN(L2), .WORD_W(W), .ISOL_DLY(D)) u_dut_b (
        .prog_clk(clk), .pReset_n(rst_n), .start(b_start),
        .cfg_data(b_data), .cfg_valid(b_valid), .cfg_ready(b_ready),
        .ccff_head(b_head), .ccff_shift_en(b_en), .ccff_tail(b_tail),
        .IO_ISOL_N(b_isol), .busy(b_busy), .done(b_done), .err(b_err)
    );

    // ---------------- A: driver / scoreboard ----------------
    logic [W-1:0] a_wq[$];      // words still to send
    logic         a_exp[$];     // expected load bits on head, in order
    int a_pushed = 0, a_widx = 0, a_stall_word = -1, a_stall_left = 0;
    int a_shifts = 0, a_gap = 0, a_n = 0;
    logic a_ready_seen = 1'b0;

    // Inputs change on the falling edge; a word whose valid meets ready here
    // is taken on the next rising edge, so its bits are queued now.
    initial begin : a_driver
        forever begin
            @(negedge clk);
            if (a_wq.size() == 0) begin
                a_valid = 1'b0;
            end else if (a_ready && a_widx == a_stall_word && a_stall_left > 0) begin
                a_valid = 1'b0;
                a_stall_left--;
            end else begin
                a_valid = 1'b1;
                a_data  = a_wq[0];
                if (a_ready) begin
                    for (int b = W - 1; b >= 0 && a_pushed < L; b--) begin
                        a_exp.push_back(a_wq[0][b]);
                        a_pushed++;
                    end
                    void'(a_wq.pop_front());
                    a_widx++;
                end
            end
        end
    end

    initial begin : a_monitor
        forever begin
            @(negedge clk);
            if (a_ready) a_ready_seen = 1'b1;
            if (a_busy && !a_en && a_shifts > 2 * L && a_shifts < 3 * L) a_gap++;
            if (a_en) begin
                a_shifts++;
                if (a_shifts <= 2 * L) begin
                    check_val("flush_probe_head", int'(a_head), int'(a_shifts == L + 1));
                end else begin
                    check_val("load_sb_has_bit", int'(a_exp.size() != 0), 1);
                    if (a_exp.size() != 0) check_val("load_head", int'(a_head), int'(a_exp.pop_front()));
                end
            end
        end
    end

    task automatic a_start_run(input int nwords, input int stall_word, input int stall_len);
        @(negedge clk);
        a_wq.delete();
        a_exp.delete();
        if (nwords > 0) begin
            a_wq.push_back(8'hA5);
            a_wq.push_back(8'h3C);
        end
        a_pushed = 0; a_widx = 0;
        a_stall_word = stall_word; a_stall_left = stall_len;
        a_shifts = 0; a_gap = 0; a_ready_seen = 1'b0;
        a_start = 1'b1;
        a_n = cyc;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic a_wait_end(output int dt);
        int i;
        i = 0;
        while (!(a_done || a_err) && i < 400) begin
            @(negedge clk);
            i++;
        end
        check_val("end_reached", int'(a_done || a_err), 1);
        dt = cyc - a_n;
    endtask

    task automatic a_check_load(input int dt_exp, input int gap_exp);
        int dt;
        a_wait_end(dt);
        check_val("done_cycle", dt, dt_exp);
        check_val("done", int'(a_done), 1);
        check_val("isol_n", int'(a_isol), 1);
        check_val("busy", int'(a_busy), 0);
        check_val("err", int'(a_err), 0);
        check_val("chain", int'(a_chain[15:0]), 'hA53C);
        check_val("shift_total", a_shifts, 3 * L);
        check_val("stall_gap", a_gap, gap_exp);
        check_val("sb_drained", a_exp.size(), 0);
    endtask

    task automatic a_check_err(input int dt_exp);
        int dt;
        a_wait_end(dt);
        check_val("err_cycle", dt, dt_exp);
        check_val("err", int'(a_err), 1);
        check_val("err_isol_n", int'(a_isol), 0);
        check_val("err_busy", int'(a_busy), 0);
        check_val("err_done", int'(a_done), 0);
        check_val("err_ready_seen", int'(a_ready_seen), 0);
        @(negedge clk);
        check_val("err_shift_en", int'(a_en), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int dt, i, b_acc, b_ready_after, b_n;

        // Reset values
        #3;
        check_val("rst_a_outputs", int'({a_ready, a_head, a_en, a_isol, a_busy, a_done, a_err}), 0);
        check_val("rst_b_outputs", int'({b_ready, b_head, b_en, b_isol, b_busy, b_done, b_err}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Nominal load: done at N+55, 48 shifts
        a_start_run(2, -1, 0);
        a_check_load(3 * L + D + 3, 0);

        // Stall: valid low for 5 cycles where the second word is wanted
        a_start_run(2, 1, 5);
        a_check_load(3 * L + D + 3 + 5, 5);

        // Short chain: marker arrives after shift 15
        a_len = 15;
        a_start_run(0, -1, 0);
        a_check_err(2 * L + 1);

        // Long chain: marker missing after shift 16
        a_len = 17;
        a_start_run(0, -1, 0);
        a_check_err(2 * L + 2);
        a_len = L;

        // Partial final word on instance B
        @(negedge clk);
        b_start = 1'b1;
        b_n = cyc;
        b_acc = 0;
        b_ready_after = 0;
        @(negedge clk);
        b_start = 1'b0;
        i = 0;
        while (!b_done && i < 300) begin
            @(negedge clk);
            i++;
            if (b_acc == 2 && b_ready) b_ready_after++;
            if (b_acc < 2) begin
                b_valid = 1'b1;
                b_data  = (b_acc == 0) ? 8'hF0 : 8'hAB;
                if (b_ready) b_acc++;
            end else begin
                b_valid = 1'b0;
            end
        end
        check_val("b_done", int'(b_done), 1);
        check_val("b_done_cycle", cyc - b_n, 3 * L2 + D + 3);
        check_val("b_chain", int'(b_chain[11:0]), 'hF0A);
        check_val("b_words_taken", b_acc, 2);
        check_val("b_ready_after_last", b_ready_after, 0);
        check_val("b_isol_n", int'(b_isol), 1);

        // Reset in the middle of LOAD, then a clean restart
        a_start_run(2, -1, 0);
        i = 0;
        while (a_shifts < 2 * L + 4 && i < 200) begin
            @(negedge clk);
            i++;
        end
        check_val("reached_load", int'(a_shifts >= 2 * L + 4), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midload_rst_outputs", int'({a_ready, a_head, a_en, a_isol, a_busy, a_done, a_err}), 0);
        repeat (2) @(negedge clk);
        a_wq.delete();
        a_exp.delete();
        rst_n = 1'b1;
        a_start_run(2, -1, 0);
        a_check_load(3 * L + D + 3, 0);

        // Start pulse during PROBE is ignored
        a_start_run(2, -1, 0);
        i = 0;
        while (a_shifts < L + 3 && i < 200) begin
            @(negedge clk);
            i++;
        end
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_check_load(3 * L + D + 3, 0);

        // Start after done clears done, isolates and re-runs FLUSH
        a_start_run(2, -1, 0);
        check_val("restart_done", int'(a_done), 0);
        check_val("restart_isol_n", int'(a_isol), 0);
        check_val("restart_busy", int'(a_busy), 1);
        check_val("restart_flush_en", int'(a_en), 1);
        check_val("restart_flush_head", int'(a_head), 0);
        a_check_load(3 * L + D + 3, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Configuration-chain sequencer for the IO tile column. It flushes and length-probes a `ccff_head`→`ccff_tail` scan chain, then serialises a word-wide bitstream into it. It gates the chain shift clock and holds `IO_ISOL_N` low until the load has completed and verified. It sits between the SoC-side bitstream source and the head of the IO tiles' configuration flip-flop chain.

## Interface
- `CHAIN_LEN`, 128: number of configuration flip-flops in the chain; must be ≥ 2.
- `WORD_W`, 8: bitstream word width; must be ≥ 1.
- `ISOL_DLY`, 4: idle cycles between the last shift and `IO_ISOL_N` release; must be ≥ 1.

Ports:
- `prog_clk` input 1: the single clock. Controller and chain both run on it.
- `pReset_n` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle pulse that begins a load. Ignored while `busy`=1.
- `cfg_data` input `WORD_W`: bitstream word. The MSB is shifted first.
- `cfg_valid` input 1 / `cfg_ready` output 1: word handshake. A transfer occurs on a cycle where both are 1.
- `ccff_head` output 1: serial data into the chain. Registered.
- `ccff_shift_en` output 1: shift enable for the chain clock gate. Registered. The chain captures `ccff_head` on each `prog_clk` edge where this is 1.
- `ccff_tail` input 1: output of the last chain flip-flop.
- `IO_ISOL_N` output 1: IO isolation control. 0 = isolated.
- `busy` output 1, `done` output 1, `err` output 1: status flags.

## Operation
- **States:** IDLE, FLUSH, PROBE, LOAD, SETTLE, DONE, ERROR.
- **Reset values:** all outputs 0. State is IDLE, all counters are 0, and the word buffer is empty.
- **IDLE:**
  - On `start`, go to FLUSH.
  - Clear `done` and `err`, set `busy`=1, and drive `IO_ISOL_N`=0.
  - `IO_ISOL_N` stays 0 from this point until DONE.
- **FLUSH:** issue exactly `CHAIN_LEN` shifts with `ccff_head`=0, then go to PROBE.
- **PROBE:**
  - Issue `CHAIN_LEN` shifts. The first has `ccff_head`=1; the rest have `ccff_head`=0.
  - `ccff_tail` is sampled in the cycle after each probe shift.
  - It must be 0 after shifts 1..`CHAIN_LEN`-1 and 1 after shift `CHAIN_LEN`.
  - Any mismatch goes to ERROR: an early 1 means the chain is short; a missing 1 means the chain is long or broken.
  - A pass goes to LOAD.
- **LOAD:**
  - A 1-word holding buffer feeds a `WORD_W`-bit shift register.
  - `cfg_ready`=1 when the buffer is empty, or when the current word's last bit is being shifted this cycle.
  - With `cfg_valid` held at 1, the load runs without bubbles.
  - When no bit is available, `ccff_shift_en`=0 and `ccff_head` holds its value. This stall has no limit.
  - The load shifts exactly `CHAIN_LEN` data bits, taken from ceil(`CHAIN_LEN`/`WORD_W`) words.
  - Unused low-order bits of the final word are discarded.
  - After the final word is accepted, `cfg_ready`=0 for the rest of LOAD.
  - After the `CHAIN_LEN`-th shift, go to SETTLE.
- **SETTLE:** `ccff_shift_en`=0 for `ISOL_DLY` cycles, then go to DONE.
- **DONE:**
  - Set `IO_ISOL_N`=1, `done`=1, `busy`=0.
  - Hold these until the next `start`, which re-enters FLUSH.
- **ERROR:**
  - Set `err`=1, `busy`=0; `IO_ISOL_N` stays 0; `ccff_shift_en`=0.
  - Only `start` leaves this state (to FLUSH).
- **`start` while `busy`:** ignored and not queued.
- **Reset mid-operation:**
  - All outputs drop to 0 asynchronously; `IO_ISOL_N`=0 immediately.
  - The partially loaded chain contents are don't-care.
  - A fresh `start` is required.
- **Shift counter:** width is clog2(`CHAIN_LEN`+1). It never wraps; its terminal compare is equality with `CHAIN_LEN`.

## Timing
- Cycle N = the cycle `start` is sampled.
- FLUSH shifts occupy cycles N+1 … N+`CHAIN_LEN` (`ccff_shift_en`=1 throughout).
- PROBE shifts occupy the next `CHAIN_LEN` cycles.
- The probe check of the final shift is made one cycle after that shift. The PROBE→LOAD transition happens in that same cycle.
- LOAD:
  - `cfg_ready` is first asserted in the first LOAD cycle.
  - The MSB of the first accepted word appears on `ccff_head` with `ccff_shift_en`=1 in the cycle after acceptance.
  - With no stalls, LOAD takes 1 + `CHAIN_LEN` cycles.
- SETTLE takes `ISOL_DLY` cycles. `IO_ISOL_N`, `done`, and `busy` change together on the following edge.
- Minimum start-to-`done` time = 3·`CHAIN_LEN` + `ISOL_DLY` + 3 cycles.

## Test plan
- **Nominal load.** `CHAIN_LEN`=16, `WORD_W`=8, behavioural 16-bit chain model, words 0xA5 then 0x3C with `cfg_valid` held at 1. Required:
  - `done`=1 and `IO_ISOL_N`=1 at N+55.
  - Chain holds 0xA53C with 0xA5's MSB at the tail flop.
  - Exactly 48 shift cycles in total.
- **Stall handling.** Same as nominal, but `cfg_valid` is dropped for 5 cycles mid-word. Required:
  - `ccff_shift_en`=0 for exactly those cycles.
  - Final chain contents are unchanged from the nominal case.
  - `done` arrives 5 cycles later.
- **Wrong chain length.** The model chain is 15 flops, then separately 17 flops. Required:
  - `err`=1 after the probe, with `IO_ISOL_N`=0 and `cfg_ready` never asserted.
- **Partial final word.** `CHAIN_LEN`=12, `WORD_W`=8, words 0xF0 then 0xAB. Required:
  - Chain = 0xF0A (upper nibble of 0xAB only).
  - `cfg_ready`=0 after the second word is accepted.
- **Reset and restart.** Assert `pReset_n`=0 mid-LOAD. Required:
  - All outputs are 0 in the same cycle.
  - A subsequent `start` completes a clean nominal load.
- **Start while busy.** Pulse `start` during PROBE; then, after `done`, pulse `start` again. Required:
  - The pulse during PROBE has no effect.
  - The pulse after `done` clears `done`, drops `IO_ISOL_N` to 0, and re-runs FLUSH.
